// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: master indices and default sizing.
package dmem_arb_pkg;
   localparam int M_CORE           = 0;
   localparam int M_DBG            = 1;
   localparam int DEF_DW           = 32;
   localparam int DEF_AW           = 32;
   localparam int DEF_STARVE_LIMIT = 4;
   localparam int DEF_CW           = 8;
endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter; at_limit tells the arbiter to force a debug-port grant.
module arb_starve_counter #(
   parameter int LIMIT = 4,
   parameter int CW    = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   logic [CW-1:0] cnt;

   assign at_limit = (cnt == CW'(LIMIT));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                  cnt <= '0;
      else if (clr)               cnt <= '0;
      else if (inc && !at_limit)  cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: fixed priority to the core, bounded wait for the debug/DMA port.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DW           = DEF_DW,
   parameter int AW           = DEF_AW,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int CW           = DEF_CW
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_m0_req,
   input  logic          i_m0_we,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [DW-1:0] i_m0_wd,
   output logic          o_m0_gnt,
   output logic          o_m0_rvalid,
   output logic [DW-1:0] o_m0_rdata,
   input  logic          i_m1_req,
   input  logic          i_m1_we,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [DW-1:0] i_m1_wd,
   output logic          o_m1_gnt,
   output logic          o_m1_rvalid,
   output logic [DW-1:0] o_m1_rdata,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wd,
   output logic          o_mem_wen,
   input  logic [DW-1:0] i_mem_rd
);
   logic       at_limit;
   logic       force_m1;
   logic [1:0] gnt;

   assign force_m1    = i_m1_req && at_limit;
   assign gnt[M_DBG]  = force_m1 || (i_m1_req && !i_m0_req);
   assign gnt[M_CORE] = i_m0_req && !force_m1;
   assign o_m0_gnt    = gnt[M_CORE];
   assign o_m1_gnt    = gnt[M_DBG];

   always_comb begin
      o_mem_addr = '0;
      o_mem_wd   = '0;
      o_mem_wen  = 1'b0;
      if (gnt[M_CORE]) begin
         o_mem_addr = i_m0_addr;
         o_mem_wd   = i_m0_wd;
         o_mem_wen  = i_m0_we;
      end else if (gnt[M_DBG]) begin
         o_mem_addr = i_m1_addr;
         o_mem_wd   = i_m1_wd;
         o_mem_wen  = i_m1_we;
      end
   end

   // a withdrawn request or a grant both restart the wait
   arb_starve_counter #(.LIMIT(STARVE_LIMIT), .CW(CW)) u_starve (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .inc      (i_m1_req && !gnt[M_DBG]),
      .clr      (gnt[M_DBG] || !i_m1_req),
      .at_limit (at_limit)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_m0_rvalid <= 1'b0;
         o_m0_rdata  <= '0;
         o_m1_rvalid <= 1'b0;
         o_m1_rdata  <= '0;
      end else begin
         o_m0_rvalid <= gnt[M_CORE] && !i_m0_we;
         o_m1_rvalid <= gnt[M_DBG] && !i_m1_we;
         if (gnt[M_CORE] && !i_m0_we) o_m0_rdata <= i_mem_rd;
         if (gnt[M_DBG] && !i_m1_we)  o_m1_rdata <= i_mem_rd;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a cycle-level reference of the sharing rules.
module tb_dmem_arbiter;
   localparam int DW = 32, AW = 32, LIM = 4, MW = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wd = '0, m1_wd = '0;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wen;
   logic [DW-1:0] m0_rdata, m1_rdata, mem_wd, mem_rd;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] mem     [MW];
   logic [DW-1:0] ref_mem [MW];

   int errors = 0, checks = 0;
   int blocked = 0;
   logic          e_v0 = 0, e_v1 = 0, g0 = 0, g1 = 0;
   logic [DW-1:0] e_rd0 = '0, e_rd1 = '0;
   logic          c_wen;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wd;
   int            g1_count;
   int            first_g1;

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_addr % MW];

   dmem_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(LIM), .CW(8)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wd(m0_wd),
      .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
      .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wd(m1_wd),
      .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
      .o_mem_addr(mem_addr), .o_mem_wd(mem_wd), .o_mem_wen(mem_wen), .i_mem_rd(mem_rd)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: entered just after a rising edge with inputs already applied.
   task automatic cycle();
      logic f;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      logic          ewen;
      #3;
      f  = m1_req && (blocked >= LIM);
      g1 = f || (m1_req && !m0_req);
      g0 = m0_req && !f;
      ea = '0; ew = '0; ewen = 1'b0;
      if (g0)      begin ea = m0_addr; ew = m0_wd; ewen = m0_we; end
      else if (g1) begin ea = m1_addr; ew = m1_wd; ewen = m1_we; end
      chk("m0_gnt", 64'(m0_gnt), 64'(g0));
      chk("m1_gnt", 64'(m1_gnt), 64'(g1));
      chk("mem_wen", 64'(mem_wen), 64'(ewen));
      chk("mem_addr", 64'(mem_addr), 64'(ea));
      chk("mem_wd", 64'(mem_wd), 64'(ew));
      c_wen = mem_wen; c_addr = mem_addr; c_wd = mem_wd;
      e_v0 = g0 && !m0_we;
      e_v1 = g1 && !m1_we;
      if (e_v0) e_rd0 = ref_mem[m0_addr % MW];
      if (e_v1) e_rd1 = ref_mem[m1_addr % MW];
      if (ewen) ref_mem[ea % MW] = ew;
      if (m1_req && !g1) blocked = blocked + 1;
      else               blocked = 0;
      @(posedge clk); #1;
      if (c_wen) mem[c_addr % MW] = c_wd;
      chk("m0_rvalid", 64'(m0_rvalid), 64'(e_v0));
      chk("m0_rdata", 64'(m0_rdata), 64'(e_rd0));
      chk("m1_rvalid", 64'(m1_rvalid), 64'(e_v1));
      chk("m1_rdata", 64'(m1_rdata), 64'(e_rd1));
   endtask

   task automatic idle();
      m0_req = 0; m0_we = 0; m1_req = 0; m1_we = 0;
   endtask

   initial begin
      for (int i = 0; i < MW; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      mem[32'h20 % MW] = 32'h12345678;
      ref_mem[32'h20 % MW] = 32'h12345678;

      #1;
      chk("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
      chk("rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
      chk("rst_m0_rdata", 64'(m0_rdata), 64'd0);
      chk("rst_m1_rdata", 64'(m1_rdata), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      cycle();

      // M0 write then read back
      m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wd = 32'hDEADBEEF;
      cycle();
      chk("m0_wr_gnt", 64'(g0), 64'd1);
      m0_we = 0; m0_wd = '0;
      cycle();
      chk("m0_rd_data", 64'(m0_rdata), 64'hDEADBEEF);
      chk("m0_rd_valid", 64'(m0_rvalid), 64'd1);
      idle(); cycle();

      // M1 alone: immediate grant, no waiting
      m1_req = 1; m1_we = 0; m1_addr = 32'h20;
      cycle();
      chk("m1_rd_data", 64'(m1_rdata), 64'h12345678);
      chk("m1_no_wait", 64'(blocked), 64'd0);
      idle(); cycle();

      // cross-master coherence
      m1_req = 1; m1_we = 1; m1_addr = 32'h8; m1_wd = 32'hA5A5A5A5;
      cycle();
      idle(); m0_req = 1; m0_addr = 32'h8;
      cycle();
      chk("coherent_rd", 64'(m0_rdata), 64'hA5A5A5A5);
      idle(); cycle();

      // both reading continuously: M1 forced on every fifth cycle
      m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
      g1_count = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (g1) g1_count++;
      end
      chk("starve_pattern", 64'(g1_count), 64'd2);
      idle(); cycle();

      // mid-cycle reset with a read response outstanding
      m0_req = 1; m0_addr = 32'h10;
      cycle();
      chk("pre_rst_valid", 64'(m0_rvalid), 64'd1);
      idle();
      #2 rst = 1'b1;
      #1;
      chk("midrst_m0_rvalid", 64'(m0_rvalid), 64'd0);
      chk("midrst_m0_rdata", 64'(m0_rdata), 64'd0);
      chk("midrst_m1_rdata", 64'(m1_rdata), 64'd0);
      chk("midrst_wen", 64'(mem_wen), 64'd0);
      e_v0 = 0; e_v1 = 0; e_rd0 = '0; e_rd1 = '0; blocked = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      cycle();

      // withdrawal restarts the wait
      m0_req = 1; m0_addr = 32'h4; m1_req = 1; m1_addr = 32'h8;
      cycle(); cycle();
      m1_req = 0;
      cycle();
      m1_req = 1;
      first_g1 = 0;
      for (int i = 1; i <= 6 && first_g1 == 0; i++) begin
         cycle();
         if (g1) first_g1 = i;
      end
      chk("withdraw_restart", 64'(first_g1), 64'd5);
      idle(); cycle();

      // randomized traffic obeying the hold-until-granted protocol
      for (int n = 0; n < 400; n++) begin
         if (!m0_req || g0) begin
            m0_req = ($urandom_range(0, 3) != 0);
            m0_we = $urandom_range(0, 1) == 1;
            m0_addr = AW'($urandom_range(0, MW - 1));
            m0_wd = $urandom;
         end
         if (m1_req && !g1 && $urandom_range(0, 7) == 0) begin
            m1_req = 0;
         end else if (!m1_req || g1) begin
            m1_req = ($urandom_range(0, 2) != 0);
            m1_we = $urandom_range(0, 1) == 1;
            m1_addr = AW'($urandom_range(0, MW - 1));
            m1_wd = $urandom;
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
